// File: rtl/tictactoe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tictactoe_pkg
// Description : Shared types and constants for the board input front end.
//               Holds the cell-select FSM state encoding, the board geometry
//               and the one-hot to cell-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;
  localparam int SEL_W     = 4;
  localparam logic [SEL_W-1:0] SEL_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  // Index of the set bit of a one-hot cell vector (cell n -> n-1).
  // A zero vector maps to SEL_NONE; callers only pass one-hot vectors.
  function automatic logic [SEL_W-1:0] onehot_to_index(input logic [NUM_CELLS-1:0] vec);
    logic [SEL_W-1:0] idx;
    idx = SEL_NONE;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (vec[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_select_encoder_btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync
// Description : Two-flop synchronizer for a bus of independent asynchronous
//               level inputs (push-buttons). Bits are not coherent with each
//               other; downstream debouncing absorbs per-bit skew.
// Ports       : clock   - system clock, rising edge
//               reset   - synchronous, active-high; clears both stages
//               async_i - raw asynchronous inputs
//               sync_o  - synchronized copy, two clocks behind async_i
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync #(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/cell_select_encoder.sv
`default_nettype none
// ============================================================================
// Module      : cell_select_encoder
// Description : Converts nine raw cell push-buttons into a registered 4-bit
//               cell index plus a one-cycle valid strobe, one strobe per
//               physical press. Buttons are synchronized, debounced on press
//               and on release, and multi-button presses are rejected.
// Ports       : clock      - system clock, rising edge
//               reset      - synchronous, active-high
//               btn[8:0]   - raw buttons, btn[0]=cell 1 .. btn[8]=cell 9
//               occupied   - (optional) cells already taken, same bit order
//               occ_reject - (optional) strobe: press on an occupied cell
//               sel[3:0]   - cell index 0..8, 4'hF = no cell yet
//               sel_valid  - one-cycle strobe, sel meaningful while high
//               multi_err  - one-cycle strobe, stable press not one-hot
//               busy       - high whenever the FSM is not in IDLE
// Options     : CELL_OCCUPIED_MASK_EN - adds occupied/occ_reject and blocks
//               strobes for presses on occupied cells.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_select_encoder
  import tictactoe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CELLS-1:0] btn,
`ifdef CELL_OCCUPIED_MASK_EN
  input  logic [NUM_CELLS-1:0] occupied,
  output logic                 occ_reject,
`endif
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_valid,
  output logic                 multi_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = '1;

  logic [NUM_CELLS-1:0] bs;

  state_e               state_q, state_d;
  logic [NUM_CELLS-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 sel_valid_q, sel_valid_d;
  logic                 multi_err_q, multi_err_d;
  logic                 busy_q, busy_d;
`ifdef CELL_OCCUPIED_MASK_EN
  logic                 occ_reject_q, occ_reject_d;
`endif

  btn_sync #(
    .WIDTH (NUM_CELLS)
  ) u_btn_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (btn),
    .sync_o  (bs)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      cnt_q        <= '0;
      sel_q        <= SEL_NONE;
      sel_valid_q  <= 1'b0;
      multi_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CELL_OCCUPIED_MASK_EN
      occ_reject_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      multi_err_q  <= multi_err_d;
      busy_q       <= busy_d;
`ifdef CELL_OCCUPIED_MASK_EN
      occ_reject_q <= occ_reject_d;
`endif
    end
  end

  // Strobes are computed on the transition so that, being registered, they
  // are high exactly during the cycle the FSM spends in the target state.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    sel_valid_d  = 1'b0;
    multi_err_d  = 1'b0;
`ifdef CELL_OCCUPIED_MASK_EN
    occ_reject_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bs != '0) begin
          snap_d  = bs;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (bs == '0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bs != snap_q) begin
          // Pattern changed (extra button, bounce): restart on the new one.
          snap_d = bs;
          cnt_d  = '0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (!$onehot(snap_q)) begin
            multi_err_d = 1'b1;
            state_d     = WAIT_RELEASE;
          end
`ifdef CELL_OCCUPIED_MASK_EN
          else if ((snap_q & occupied) != '0) begin
            occ_reject_d = 1'b1;
            state_d      = WAIT_RELEASE;
          end
`endif
          else begin
            sel_valid_d = 1'b1;
            sel_d       = onehot_to_index(snap_q);
            state_d     = EMIT;
          end
        end else if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      EMIT: begin
        cnt_d   = '0;
        state_d = WAIT_RELEASE;
      end

      WAIT_RELEASE: begin
        // Every button must read released for the full debounce window;
        // any activity restarts the window and never yields a strobe.
        if (bs != '0) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign multi_err  = multi_err_q;
  assign busy       = busy_q;
`ifdef CELL_OCCUPIED_MASK_EN
  assign occ_reject = occ_reject_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cell_select_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_select_encoder
// Description : Self-checking bench for cell_select_encoder. A run-length
//               model of the press/release rules predicts every output each
//               cycle; directed scenarios add latency and pulse-count checks,
//               followed by randomized button activity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_select_encoder;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] btn;
  logic [3:0] sel;
  logic       sel_valid;
  logic       multi_err;
  logic       busy;
`ifdef CELL_OCCUPIED_MASK_EN
  logic [8:0] occupied;
  logic       occ_reject;
`endif

  always #5 clock = ~clock;

  cell_select_encoder #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn        (btn),
`ifdef CELL_OCCUPIED_MASK_EN
    .occupied   (occupied),
    .occ_reject (occ_reject),
`endif
    .sel        (sel),
    .sel_valid  (sel_valid),
    .multi_err  (multi_err),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model --------------------------------------
  // Armed: a press is accepted once the same nonzero pattern has been seen
  // on D+1 consecutive synchronized samples. Disarmed: re-arms after D
  // consecutive all-released samples (the emit cycle itself is not counted).
  logic [8:0] m_s1, m_s2, m_pat, m_occ_in;
  int         m_run, m_zero;
  bit         m_armed, m_skip;
  logic [3:0] m_sel;
  bit         m_valid, m_merr, m_busy, m_occ;

  task automatic model_step(input logic r, input logic [8:0] b);
    logic [8:0] bs;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_pat = '0; m_run = 0; m_zero = 0;
      m_armed = 1; m_skip = 0; m_sel = 4'hF;
      m_valid = 0; m_merr = 0; m_busy = 0; m_occ = 0;
      return;
    end
    bs = m_s2; m_s2 = m_s1; m_s1 = b;
    m_valid = 0; m_merr = 0; m_occ = 0;
    if (m_armed) begin
      if (bs == 0) m_run = 0;
      else if (m_run > 0 && bs == m_pat) m_run++;
      else begin m_pat = bs; m_run = 1; end
      if (m_run == D + 1) begin
        m_armed = 0; m_run = 0; m_zero = 0; m_skip = 0;
        if ($countones(m_pat) != 1) m_merr = 1;
`ifdef CELL_OCCUPIED_MASK_EN
        else if ((m_pat & m_occ_in) != 0) m_occ = 1;
`endif
        else begin
          m_valid = 1; m_skip = 1;
          for (int i = 0; i < 9; i++) if (m_pat[i]) m_sel = 4'(i);
        end
      end
    end else begin
      if (m_skip) m_skip = 0;
      else begin
        if (bs == 0) m_zero++; else m_zero = 0;
        if (m_zero == D) m_armed = 1;
      end
    end
    m_busy = !m_armed || (m_run > 0);
  endtask

  int n_valid = 0;
  int n_merr  = 0;
  int n_occ   = 0;

  // Called at a negedge: drive, let one rising edge pass, check at negedge.
  task automatic tick(input logic r, input logic [8:0] b);
    reset = r;
    btn   = b;
    @(posedge clock);
    model_step(r, b);
    @(negedge clock);
    check_val("sel", 32'(sel), 32'(m_sel));
    check_val("sel_valid", 32'(sel_valid), 32'(m_valid));
    check_val("multi_err", 32'(multi_err), 32'(m_merr));
    check_val("busy", 32'(busy), 32'(m_busy));
`ifdef CELL_OCCUPIED_MASK_EN
    check_val("occ_reject", 32'(occ_reject), 32'(m_occ));
    if (occ_reject) n_occ++;
`endif
    if (sel_valid) n_valid++;
    if (multi_err) n_merr++;
  endtask

  task automatic idle_for(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 9'h000);
  endtask

  initial begin
    int v0, e0, first;
    int rcyc;
    logic [8:0] pat;
    reset = 1'b1;
    btn   = '0;
`ifdef CELL_OCCUPIED_MASK_EN
    occupied = '0;
    m_occ_in = '0;
`endif
    @(negedge clock);
    tick(1'b1, 9'h000);
    tick(1'b1, 9'h000);

    // Reset then idle
    idle_for(50);
    check_val("idle_sel", 32'(sel), 32'h0000_000F);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Clean press on cell 5: strobe after edge D+2, busy falls after release
    v0 = n_valid; first = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 9'b000010000);
      if (sel_valid && first < 0) first = i;
    end
    check_val("clean_latency", 32'(first), 32'(D + 2));
    check_val("clean_count", 32'(n_valid - v0), 32'd1);
    check_val("clean_sel", 32'(sel), 32'd4);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 9'h000);
      if (!busy && first < 0) first = i;
    end
    check_val("release_busy_drop", 32'(first), 32'(D + 1));

    // Bounce on cell 1, then stable hold
    v0 = n_valid;
    for (int i = 0; i < 10; i++) tick(1'b0, (i % 2 == 0) ? 9'h001 : 9'h000);
    check_val("bounce_no_strobe", 32'(n_valid - v0), 32'd0);
    for (int i = 0; i < 20; i++) tick(1'b0, 9'h001);
    check_val("bounce_count", 32'(n_valid - v0), 32'd1);
    check_val("bounce_sel", 32'(sel), 32'd0);
    idle_for(10);

    // Double press rejected, then single cell 9 accepted
    v0 = n_valid; e0 = n_merr;
    for (int i = 0; i < 20; i++) tick(1'b0, 9'b100000001);
    check_val("double_merr", 32'(n_merr - e0), 32'd1);
    check_val("double_no_strobe", 32'(n_valid - v0), 32'd0);
    idle_for(10);
    for (int i = 0; i < 20; i++) tick(1'b0, 9'b100000000);
    check_val("cell9_count", 32'(n_valid - v0), 32'd1);
    check_val("cell9_sel", 32'(sel), 32'd8);
    idle_for(10);

    // Hold cell 3 then add cell 4: no additional strobe
    v0 = n_valid;
    for (int i = 0; i < 15; i++) tick(1'b0, 9'b000000100);
    check_val("hold_sel", 32'(sel), 32'd2);
    for (int i = 0; i < 20; i++) tick(1'b0, 9'b000001100);
    check_val("hold_add_count", 32'(n_valid - v0), 32'd1);
    idle_for(10);

    // Reset in the middle of debouncing cell 7
    v0 = n_valid; first = -1;
    for (int i = 0; i < 20; i++) begin
      tick(i == 4, 9'b001000000);
      if (sel_valid && first < 0) first = i;
    end
    check_val("rst_mid_latency", 32'(first), 32'(5 + D + 2));
    check_val("rst_mid_sel", 32'(sel), 32'd6);
    idle_for(10);

`ifdef CELL_OCCUPIED_MASK_EN
    // Occupied cell: rejected, sel unchanged
    occupied = 9'b000000100; m_occ_in = occupied;
    v0 = n_valid; e0 = n_occ;
    for (int i = 0; i < 20; i++) tick(1'b0, 9'b000000100);
    check_val("occ_reject_count", 32'(n_occ - e0), 32'd1);
    check_val("occ_no_strobe", 32'(n_valid - v0), 32'd0);
    check_val("occ_sel_kept", 32'(sel), 32'd6);
    idle_for(10);
`endif

    // Randomized activity, checked cycle by cycle against the model
    rcyc = 0;
    while (rcyc < 3000) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 14);
`ifdef CELL_OCCUPIED_MASK_EN
      occupied = 9'($urandom); m_occ_in = occupied;
`endif
      if (kind <= 5) pat = 9'(1) << $urandom_range(0, 8);
      else if (kind == 6) pat = 9'($urandom_range(1, 511));
      else pat = 9'h000;
      for (int i = 0; i < len; i++) begin
        case (kind)
          7: tick(1'b0, (i % 2 == 0) ? (9'(1) << (i % 9)) : 9'h000);
          9: tick(i == 0, 9'(1) << $urandom_range(0, 8));
          default: tick(1'b0, pat);
        endcase
      end
      rcyc += len;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
